// File: rtl/dht11_pkg.sv
// Shared constants, state encoding and frame helpers for the DHT11 single-wire reader.
package dht11_pkg;

  typedef logic [3:0] state_t;

  localparam state_t StIdle     = 4'd0;
  localparam state_t StStartLow = 4'd1;
  localparam state_t StRelease  = 4'd2;
  localparam state_t StRespLow  = 4'd3;
  localparam state_t StRespHigh = 4'd4;
  localparam state_t StBitLow   = 4'd5;
  localparam state_t StBitHigh  = 4'd6;
  localparam state_t StPublish  = 4'd7;
  localparam state_t StError    = 4'd8;

  localparam int unsigned FRAME_BITS     = 40;
  localparam int unsigned HUM_INT_IDX    = 0;
  localparam int unsigned HUM_FLOAT_IDX  = 1;
  localparam int unsigned TEMP_INT_IDX   = 2;
  localparam int unsigned TEMP_FLOAT_IDX = 3;
  localparam int unsigned CRC_IDX        = 4;

  // Byte 0 is the first byte on the wire, i.e. the most significant byte of the frame.
  function automatic logic [7:0] frame_byte(input logic [FRAME_BITS-1:0] f,
                                            input int unsigned idx);
    return 8'(f >> (8 * (FRAME_BITS / 8 - 1 - idx)));
  endfunction

  function automatic logic [7:0] crc_sum(input logic [FRAME_BITS-1:0] f);
    logic [7:0] s;
    s = '0;
    for (int unsigned i = 0; i < CRC_IDX; i++) begin
      s = s + frame_byte(f, i);
    end
    return s;
  endfunction

endpackage

// File: rtl/dht11_reader_if.sv
// Controller-facing signal bundle of the DHT11 reader, including the sensed/driven line.
interface dht11_reader_if;
  logic       i_start;
  logic       i_dht_data;
  logic       o_dht_oe;
  logic [7:0] HUM_INT;
  logic [7:0] HUM_FLOAT;
  logic [7:0] TEMP_INT;
  logic [7:0] TEMP_FLOAT;
  logic [7:0] CRC;
  logic       o_crc_ok;
  logic       o_done;
  logic       o_busy;
  logic       o_error;

  modport master (
    output i_start, i_dht_data,
    input  o_dht_oe, HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT, CRC,
    input  o_crc_ok, o_done, o_busy, o_error
  );

  modport slave (
    input  i_start, i_dht_data,
    output o_dht_oe, HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT, CRC,
    output o_crc_ok, o_done, o_busy, o_error
  );
endinterface

// File: rtl/us_timebase.sv
// Free-running microsecond tick: one-cycle pulse every CLK_FREQ_HZ/1e6 clocks.
module us_timebase #(
  parameter int unsigned CLK_FREQ_HZ = 50000000
) (
  input  logic clock,
  input  logic reset,
  output logic us_tick_o
);

  localparam int unsigned Div  = CLK_FREQ_HZ / 1000000;
  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;

  logic [CntW-1:0] cnt_q;
  logic            tick_q;
  logic            wrap;

  assign wrap      = (cnt_q == CntW'(Div - 1));
  assign us_tick_o = tick_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= wrap;
      cnt_q  <= wrap ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/dht11_reader.sv
// DHT11 transaction engine: start pulse, response handshake, 40-bit capture and publish.
module dht11_reader
  import dht11_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ   = 50000000,
  parameter int unsigned START_LOW_US  = 18000,
  parameter int unsigned RELEASE_US    = 30,
  parameter int unsigned BIT_THRESH_US = 50,
  parameter int unsigned TIMEOUT_US    = 255
) (
  input logic           clock,
  input logic           reset,
  dht11_reader_if.slave bus
);

  logic                  us_tick;
  state_t                state_q, state_d;
  logic [15:0]           us_cnt_q, us_cnt_inc;
  logic [5:0]            bit_idx_q, bit_idx_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d, pub_q;
  logic                  sync1_q, sync2_q, prev_q;
  logic                  crc_ok_q, done_q, error_q;
  logic                  rise, fall, timeout, publish, set_err, clr_err;

  us_timebase #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ)
  ) u_timebase (
    .clock    (clock),
    .reset    (reset),
    .us_tick_o(us_tick)
  );

  assign rise = sync2_q & ~prev_q;
  assign fall = ~sync2_q & prev_q;

  // Thresholds compare against the count including this cycle's tick, so a phase of N us
  // lasts exactly N ticks.
  assign us_cnt_inc = (us_tick && us_cnt_q != 16'hFFFF) ? us_cnt_q + 16'd1 : us_cnt_q;
  assign timeout    = us_cnt_inc > 16'(TIMEOUT_US);

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    publish   = 1'b0;
    set_err   = 1'b0;
    clr_err   = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.i_start) begin
          state_d   = StStartLow;
          bit_idx_d = '0;
          shift_d   = '0;
          clr_err   = 1'b1;
        end
      end
      StStartLow: if (us_cnt_inc == 16'(START_LOW_US)) state_d = StRelease;
      StRelease:  if (us_cnt_inc == 16'(RELEASE_US))   state_d = StRespLow;
      StRespLow: begin
        if (rise)         state_d = StRespHigh;
        else if (timeout) state_d = StError;
      end
      StRespHigh: begin
        if (fall)         state_d = StBitLow;
        else if (timeout) state_d = StError;
      end
      StBitLow: begin
        if (rise)         state_d = StBitHigh;
        else if (timeout) state_d = StError;
      end
      StBitHigh: begin
        if (fall) begin
          shift_d   = {shift_q[FRAME_BITS-2:0], us_cnt_inc > 16'(BIT_THRESH_US)};
          bit_idx_d = bit_idx_q + 6'd1;
          state_d   = (bit_idx_q == 6'(FRAME_BITS - 1)) ? StPublish : StBitLow;
        end else if (timeout) begin
          state_d = StError;
        end
      end
      StPublish: begin
        publish = 1'b1;
        state_d = StIdle;
      end
      StError: begin
        set_err = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Synchronizer resets to the idle (pulled-up) level so reset never fakes an edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      us_cnt_q  <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      pub_q     <= '0;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      prev_q    <= 1'b1;
      crc_ok_q  <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      us_cnt_q  <= (state_d != state_q) ? 16'd0 : us_cnt_inc;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      sync1_q   <= bus.i_dht_data;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      done_q    <= publish;
      if (publish) begin
        pub_q    <= shift_q;
        crc_ok_q <= (crc_sum(shift_q) == frame_byte(shift_q, CRC_IDX));
      end
      if (clr_err)      error_q <= 1'b0;
      else if (set_err) error_q <= 1'b1;
    end
  end

  assign bus.o_dht_oe   = (state_q == StStartLow);
  assign bus.o_busy     = (state_q != StIdle);
  assign bus.o_done     = done_q;
  assign bus.o_error    = error_q;
  assign bus.o_crc_ok   = crc_ok_q;
  assign bus.HUM_INT    = frame_byte(pub_q, HUM_INT_IDX);
  assign bus.HUM_FLOAT  = frame_byte(pub_q, HUM_FLOAT_IDX);
  assign bus.TEMP_INT   = frame_byte(pub_q, TEMP_INT_IDX);
  assign bus.TEMP_FLOAT = frame_byte(pub_q, TEMP_FLOAT_IDX);
  assign bus.CRC        = frame_byte(pub_q, CRC_IDX);

endmodule

// File: tb/tb_dht11_reader.sv
// Directed bench for dht11_reader at 1 MHz with a behavioural DHT11 sensor on the line.
`timescale 1ns/1ps
module tb_dht11_reader;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   errors   = 0;
  int   done_cnt = 0;

  always #5 clock = ~clock;

  dht11_reader_if bus ();

  dht11_reader #(
    .CLK_FREQ_HZ  (1000000),
    .START_LOW_US (20),
    .RELEASE_US   (30),
    .BIT_THRESH_US(50),
    .TIMEOUT_US   (255)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always @(negedge clock) if (bus.o_done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [39:0] f, input logic ok);
    check({tag, "_hum_int"},    40'(bus.HUM_INT),    40'(f[39:32]));
    check({tag, "_hum_float"},  40'(bus.HUM_FLOAT),  40'(f[31:24]));
    check({tag, "_temp_int"},   40'(bus.TEMP_INT),   40'(f[23:16]));
    check({tag, "_temp_float"}, 40'(bus.TEMP_FLOAT), 40'(f[15:8]));
    check({tag, "_crc"},        40'(bus.CRC),        40'(f[7:0]));
    check({tag, "_crc_ok"},     40'(bus.o_crc_ok),   40'(ok));
  endtask

  task automatic pulse_start();
    @(negedge clock);
    bus.i_start = 1'b1;
    @(negedge clock);
    bus.i_start = 1'b0;
  endtask

  // Sensor: answers the host pulse and sends 'bits' MSB first; stops in the high phase of
  // bit abort_bit when it is in range. With restart set, i_start is re-pulsed mid-frame.
  task automatic sensor_frame(input logic [39:0] bits, input int abort_bit, input bit restart);
    int n;
    int hi;
    n = 0;
    while (bus.o_dht_oe !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("oe_asserted", 40'(bus.o_dht_oe), 40'd1);
    hi = 0;
    while (bus.o_dht_oe === 1'b1 && hi < 1000) begin
      bus.i_start = restart && (hi == 5);
      @(negedge clock);
      hi++;
    end
    bus.i_start = 1'b0;
    check("oe_low_us", 40'(hi), 40'd20);
    repeat (20) @(negedge clock);
    bus.i_dht_data = 1'b0;
    repeat (80) @(negedge clock);
    bus.i_dht_data = 1'b1;
    repeat (80) @(negedge clock);
    for (int i = 0; i < 40; i++) begin
      bus.i_dht_data = 1'b0;
      bus.i_start    = restart && (i == 10);
      @(negedge clock);
      bus.i_start = 1'b0;
      repeat (49) @(negedge clock);
      bus.i_dht_data = 1'b1;
      if (i == abort_bit) begin
        repeat (10) @(negedge clock);
        return;
      end
      repeat (bits[39-i] ? 70 : 27) @(negedge clock);
    end
    bus.i_dht_data = 1'b0;
    repeat (50) @(negedge clock);
    bus.i_dht_data = 1'b1;
    repeat (5) @(negedge clock);
  endtask

  task automatic run_frame(input string tag, input logic [39:0] f, input logic ok,
                           input bit restart);
    int d0;
    d0 = done_cnt;
    pulse_start();
    sensor_frame(f, -1, restart);
    check({tag, "_done_count"}, 40'(done_cnt - d0), 40'd1);
    check_outputs(tag, f, ok);
    check({tag, "_error"}, 40'(bus.o_error), 40'd0);
    check({tag, "_busy"},  40'(bus.o_busy),  40'd0);
  endtask

  initial begin
    int d0;
    int n;
    bus.i_start    = 1'b0;
    bus.i_dht_data = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_oe",    40'(bus.o_dht_oe), 40'd0);
    check("rst_busy",  40'(bus.o_busy),   40'd0);
    check("rst_done",  40'(bus.o_done),   40'd0);
    check("rst_error", 40'(bus.o_error),  40'd0);
    check_outputs("rst", 40'h0, 1'b0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    run_frame("f1", 40'h37_00_19_00_50, 1'b1, 1'b0);
    run_frame("f2", 40'h37_00_19_00_51, 1'b0, 1'b0);
    run_frame("wrap", 40'hFF_FF_02_00_00, 1'b1, 1'b0);

    // Silent sensor: line stays high after release, so RESP_LOW must time out.
    d0 = done_cnt;
    pulse_start();
    n = 0;
    while (bus.o_dht_oe === 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    n = 0;
    while (bus.o_error !== 1'b1 && n < 600) begin
      @(negedge clock);
      n++;
    end
    check("silent_error", 40'(bus.o_error), 40'd1);
    check("silent_delay_window", 40'(n >= 270 && n <= 300), 40'd1);
    check("silent_no_done", 40'(done_cnt - d0), 40'd0);
    check("silent_busy", 40'(bus.o_busy), 40'd0);
    check_outputs("silent_keep", 40'hFF_FF_02_00_00, 1'b1);

    // Reset mid-frame in the high phase of bit 20.
    d0 = done_cnt;
    pulse_start();
    check("restart_clears_error", 40'(bus.o_error), 40'd0);
    sensor_frame(40'h37_00_19_00_50, 20, 1'b0);
    check("abort_busy_before", 40'(bus.o_busy), 40'd1);
    reset = 1'b1;
    #1;
    check("abort_oe",   40'(bus.o_dht_oe), 40'd0);
    check("abort_busy", 40'(bus.o_busy),   40'd0);
    repeat (2) @(negedge clock);
    check("abort_no_done", 40'(done_cnt - d0), 40'd0);
    check_outputs("abort", 40'h0, 1'b0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    run_frame("after_abort", 40'h37_00_19_00_50, 1'b1, 1'b0);
    run_frame("restart_ignored", 40'h12_34_56_78_14, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dht11_reader.md
Name: dht11_reader

Overview:
- Single-wire DHT11 front end; sits directly upstream of the UART request controller.
- On a start request it runs one complete sensor transaction: host start pulse, sensor response, then 40 data bits.
- Presents HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT and CRC as stable registers, plus done, crc_ok and error flags for the controller.

Parameters:
- CLK_FREQ_HZ, 50000000, system clock frequency; must be an integer multiple of 1 MHz.
- START_LOW_US, 18000, host start-pulse low time in µs.
- RELEASE_US, 30, host release time before sampling the sensor response.
- BIT_THRESH_US, 50, high-phase length above which a bit decodes as 1.
- TIMEOUT_US, 255, maximum wait in any sensor-driven phase.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- i_start  in  1  single-cycle request; honoured only in IDLE
- i_dht_data  in  1  sensed level of the bidirectional DHT line (pulled up externally)
- o_dht_oe  out  1  1 = drive the line low; 0 = release (tristate handled at top level)
- HUM_INT  out  8  byte 0 of the last completed frame
- HUM_FLOAT  out  8  byte 1
- TEMP_INT  out  8  byte 2
- TEMP_FLOAT  out  8  byte 3
- CRC  out  8  byte 4
- o_crc_ok  out  1  1 when CRC == low 8 bits of (b0+b1+b2+b3) for the last completed frame
- o_done  out  1  one-cycle pulse when a frame completes
- o_busy  out  1  high whenever state is not IDLE
- o_error  out  1  sticky timeout flag; cleared by the next accepted i_start

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0.
- Reset is asynchronous active-high. Asserting it mid-transaction forces IDLE and releases the line (o_dht_oe=0) in the same instant. No partial frame is ever published.
- i_dht_data passes through a 2-flop synchronizer. Edge detection uses the synchronized value and its previous sample.
- us_tick: pulse every CLK_FREQ_HZ/1e6 clocks; free-running, reset to 0.
- us_cnt: 16-bit, increments on us_tick, cleared on every state transition, saturates at 0xFFFF.
- State machine transitions:
  - IDLE: on i_start → START_LOW; clear o_error, bit_idx and shift register. i_start in any other state is ignored.
  - START_LOW: o_dht_oe=1. At us_cnt==START_LOW_US → RELEASE.
  - RELEASE: o_dht_oe=0. At us_cnt==RELEASE_US → RESP_LOW.
  - RESP_LOW: wait for the synchronized line to go high → RESP_HIGH.
  - RESP_HIGH: wait for falling edge → BIT_LOW.
  - BIT_LOW: wait for rising edge → BIT_HIGH.
  - BIT_HIGH: on falling edge, shift in (us_cnt > BIT_THRESH_US), MSB first, and increment bit_idx. If bit_idx reaches 40 → PUBLISH, else → BIT_LOW.
  - PUBLISH, one cycle: load the five output bytes from the 40-bit shift register (first received byte → HUM_INT), compute o_crc_ok, pulse o_done → IDLE.
  - ERROR, one cycle: set o_error, o_dht_oe=0 → IDLE. Output bytes keep their previous values.
- Timeout: in RESP_LOW, RESP_HIGH, BIT_LOW or BIT_HIGH, us_cnt > TIMEOUT_US → ERROR.
- Checksum: 8-bit wraparound sum; carry is discarded.
- Latency from i_start to o_done: START_LOW_US + RELEASE_US + sensor frame time + about 4 clocks.
- Simultaneous timeout and edge in the same cycle: the edge wins.
- Sensor edge during START_LOW or RELEASE: ignored.

Decomposition:
- Package dht11_pkg holds:
  - state enum (IDLE, START_LOW, RELEASE, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, PUBLISH, ERROR)
  - FRAME_BITS=40
  - byte index constants HUM_INT_IDX=0 … CRC_IDX=4
- Sub-module us_timebase, parameterized by CLK_FREQ_HZ, generates us_tick. The FSM, synchronizer and shift register stay in the top module.

Test Plan:
- Setup for all scenarios: CLK_FREQ_HZ=1000000 (1 tick/clock), START_LOW_US=20. Sensor model drives response lows of 80 µs, bit lows of 50 µs, and highs of 27 µs for 0 or 70 µs for 1.
- Frame 0x37,0x00,0x19,0x00,0x50 → o_done once; HUM_INT=0x37, TEMP_INT=0x19, CRC=0x50, o_crc_ok=1, o_error=0; o_dht_oe high exactly 20 µs.
- Frame 0x37,0x00,0x19,0x00,0x51 → all bytes loaded, o_crc_ok=0, o_done pulses.
- Checksum wraparound: bytes 0xFF,0xFF,0x02,0x00 with CRC 0x00 → o_crc_ok=1.
- Sensor silent (line held high after release) → o_error=1 after TIMEOUT_US in RESP_LOW; no o_done; output bytes unchanged from the previous frame.
- Reset asserted during BIT_HIGH at bit 20 → o_dht_oe=0 and o_busy=0 immediately. A following i_start plus a full frame completes normally.
- i_start repeated while busy → ignored; exactly one o_done; the START_LOW pulse is not restarted.
